// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 definitions used by the fetch, decode/write-back and
// execute stages.
//   - icode constants IHALT..IPOPQ (0..11)
//   - register indices RSP (4'h4) and RNONE (4'hF)
//   - default data width N_DEFAULT and register file depth RF_DEPTH
package y86_pkg;

  localparam int N_DEFAULT = 64;
  localparam int RF_DEPTH  = 15;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RSP     = 4'h4;
  localparam logic [3:0] RNONE   = 4'hF;

endpackage

// File: rtl/reg_file.sv
// reg_file: 15 x N register file for the Y86-64 decode/write-back stage.
// Ports:
//   clk, reset             - clock; synchronous active-high reset clears all entries
//   ra_addr/ra_data        - combinational read port A (index 4'hF reads 0)
//   rb_addr/rb_data        - combinational read port B (index 4'hF reads 0)
//   we_e/dst_e/val_e       - write port E
//   we_m/dst_m/val_m       - write port M; wins over E when both target one entry
// Writes to index 4'hF are discarded.
module reg_file
  import y86_pkg::*;
#(
  parameter int N = y86_pkg::N_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   ra_addr,
  input  logic [3:0]   rb_addr,
  output logic [N-1:0] ra_data,
  output logic [N-1:0] rb_data,
  input  logic         we_e,
  input  logic [3:0]   dst_e,
  input  logic [N-1:0] val_e,
  input  logic         we_m,
  input  logic [3:0]   dst_m,
  input  logic [N-1:0] val_m
);

  logic [N-1:0] regs_q [RF_DEPTH];
  logic [N-1:0] regs_d [RF_DEPTH];

  // Next-state of every entry; M is applied after E so it wins on a collision.
  // Index 4'hF never matches a loop index, so such writes fall away.
  always_comb begin
    for (int i = 0; i < RF_DEPTH; i++) begin
      regs_d[i] = regs_q[i];
      if (we_m && (dst_m == 4'(i))) begin
        regs_d[i] = val_m;
      end else if (we_e && (dst_e == 4'(i))) begin
        regs_d[i] = val_e;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // Storage update with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read ports; an address with no matching entry (4'hF) returns zero.
  always_comb begin
    ra_data = '0;
    rb_data = '0;
    for (int i = 0; i < RF_DEPTH; i++) begin
      if (ra_addr == 4'(i)) begin
        ra_data = regs_q[i];
      end else begin
        ra_data = ra_data;
      end
      if (rb_addr == 4'(i)) begin
        rb_data = regs_q[i];
      end else begin
        rb_data = rb_data;
      end
    end
  end

endmodule

// File: rtl/decode_writeback.sv
// decode_writeback: Y86-64 decode / write-back stage.
// Decodes d_icode/d_rA/d_rB into source registers and registers valA/valB
// (1-cycle latency, held until the next d_valid). Resolves write-back
// destinations from w_icode/w_rA/w_rB/w_cnd and commits w_valE/w_valM to the
// register file when w_valid is high.
// Ports:
//   clk, reset                      - clock; synchronous active-high reset
//   d_valid, d_icode, d_rA, d_rB    - decode request
//   w_valid, w_icode, w_rA, w_rB,
//   w_cnd, w_valE, w_valM           - write-back request
//   valA, valB, out_valid           - registered operands to execute
// Configuration macro: DECODE_WB_FORWARD_EN
//   defined   - same-cycle read of a register being written returns the
//               incoming value (M over E)
//   undefined - same-cycle read returns the pre-write value
module decode_writeback
  import y86_pkg::*;
#(
  parameter int N = y86_pkg::N_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         d_valid,
  input  logic [3:0]   d_icode,
  input  logic [3:0]   d_rA,
  input  logic [3:0]   d_rB,
  input  logic         w_valid,
  input  logic [3:0]   w_icode,
  input  logic [3:0]   w_rA,
  input  logic [3:0]   w_rB,
  input  logic         w_cnd,
  input  logic [N-1:0] w_valE,
  input  logic [N-1:0] w_valM,
  output logic [N-1:0] valA,
  output logic [N-1:0] valB,
  output logic         out_valid
);

  logic [3:0]   src_a, src_b, dst_e, dst_m;
  logic [N-1:0] rf_a, rf_b, rd_a, rd_b;
  logic [N-1:0] val_a_d, val_a_q, val_b_d, val_b_q;
  logic         out_valid_d, out_valid_q;

  // Source register selection from the decode-side instruction.
  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    case (d_icode)
      IRRMOVQ, IRMMOVQ, IOPQ, IPUSHQ: src_a = d_rA;
      IRET, IPOPQ:                    src_a = RSP;
      default:                        src_a = RNONE;
    endcase
    case (d_icode)
      IRMMOVQ, IMRMOVQ, IOPQ:         src_b = d_rB;
      ICALL, IRET, IPUSHQ, IPOPQ:     src_b = RSP;
      default:                        src_b = RNONE;
    endcase
  end

  // Destination register selection; rrmovq only writes when its condition holds.
  always_comb begin
    dst_e = RNONE;
    dst_m = RNONE;
    case (w_icode)
      IIRMOVQ, IOPQ:                  dst_e = w_rB;
      IRRMOVQ:                        dst_e = w_cnd ? w_rB : RNONE;
      ICALL, IRET, IPUSHQ, IPOPQ:     dst_e = RSP;
      default:                        dst_e = RNONE;
    endcase
    case (w_icode)
      IMRMOVQ, IPOPQ:                 dst_m = w_rA;
      default:                        dst_m = RNONE;
    endcase
  end

  reg_file #(.N(N)) u_reg_file (
    .clk     (clk),
    .reset   (reset),
    .ra_addr (src_a),
    .rb_addr (src_b),
    .ra_data (rf_a),
    .rb_data (rf_b),
    .we_e    (w_valid),
    .dst_e   (dst_e),
    .val_e   (w_valE),
    .we_m    (w_valid),
    .dst_m   (dst_m),
    .val_m   (w_valM)
  );

`ifdef DECODE_WB_FORWARD_EN
  // Write-through bypass of the value being committed this cycle, M over E.
  always_comb begin
    rd_a = rf_a;
    rd_b = rf_b;
    if (w_valid && (src_a != RNONE) && (src_a == dst_m)) begin
      rd_a = w_valM;
    end else if (w_valid && (src_a != RNONE) && (src_a == dst_e)) begin
      rd_a = w_valE;
    end else begin
      rd_a = rf_a;
    end
    if (w_valid && (src_b != RNONE) && (src_b == dst_m)) begin
      rd_b = w_valM;
    end else if (w_valid && (src_b != RNONE) && (src_b == dst_e)) begin
      rd_b = w_valE;
    end else begin
      rd_b = rf_b;
    end
  end
`else
  // No bypass: a same-cycle read sees the pre-write register contents.
  always_comb begin
    rd_a = rf_a;
    rd_b = rf_b;
  end
`endif

  // Operand output next-state: capture on d_valid, otherwise hold.
  always_comb begin
    out_valid_d = d_valid;
    val_a_d     = val_a_q;
    val_b_d     = val_b_q;
    if (d_valid) begin
      val_a_d = rd_a;
      val_b_d = rd_b;
    end else begin
      val_a_d = val_a_q;
      val_b_d = val_b_q;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      val_a_q     <= '0;
      val_b_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      val_a_q     <= val_a_d;
      val_b_q     <= val_b_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign valA      = val_a_q;
  assign valB      = val_b_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_decode_writeback.sv
// tb_decode_writeback: directed self-checking bench for decode_writeback.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_decode_writeback;

  localparam int N = 64;

  logic         clk;
  logic         reset;
  logic         d_valid;
  logic [3:0]   d_icode, d_rA, d_rB;
  logic         w_valid;
  logic [3:0]   w_icode, w_rA, w_rB;
  logic         w_cnd;
  logic [N-1:0] w_valE, w_valM;
  logic [N-1:0] valA, valB;
  logic         out_valid;

  int n_checks;
  int n_fails;
  logic [N-1:0] exp_fwd;

  decode_writeback #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .d_valid   (d_valid),
    .d_icode   (d_icode),
    .d_rA      (d_rA),
    .d_rB      (d_rB),
    .w_valid   (w_valid),
    .w_icode   (w_icode),
    .w_rA      (w_rA),
    .w_rB      (w_rB),
    .w_cnd     (w_cnd),
    .w_valE    (w_valE),
    .w_valM    (w_valM),
    .valA      (valA),
    .valB      (valB),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_dec(input logic v, input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb);
    d_valid = v;
    d_icode = ic;
    d_rA    = ra;
    d_rB    = rb;
  endtask

  task automatic set_wb(input logic v, input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                        input logic cnd, input logic [N-1:0] ve, input logic [N-1:0] vm);
    w_valid = v;
    w_icode = ic;
    w_rA    = ra;
    w_rB    = rb;
    w_cnd   = cnd;
    w_valE  = ve;
    w_valM  = vm;
  endtask

  // One clock edge, then back to the falling edge with all requests cleared.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    set_dec(1'b0, 4'h1, 4'hF, 4'hF);
    set_wb(1'b0, 4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset    = 1'b1;
    set_dec(1'b0, 4'h1, 4'hF, 4'hF);
    set_wb(1'b0, 4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0);
    @(negedge clk);
    step();
    check_eq("rst_valA", valA, 64'h0);
    check_eq("rst_valB", valB, 64'h0);
    check_eq("rst_out_valid", {63'h0, out_valid}, 64'h1 & 64'h0);
    reset = 1'b0;

    // OPq r1,r2 on a cleared file
    set_dec(1'b1, 4'h6, 4'h1, 4'h2);
    step();
    check_eq("opq_valA", valA, 64'h0);
    check_eq("opq_valB", valB, 64'h0);
    check_eq("opq_out_valid", {63'h0, out_valid}, 64'h1);

    // irmovq 0x1234 -> r5
    set_wb(1'b1, 4'h3, 4'hF, 4'h5, 1'b0, 64'h1234, 64'h0);
    step();
    check_eq("idle_out_valid", {63'h0, out_valid}, 64'h0);
    set_dec(1'b1, 4'h6, 4'h5, 4'hF);
    step();
    check_eq("irmov_r5", valA, 64'h1234);
    check_eq("rnone_valB", valB, 64'h0);
    step();
    check_eq("hold_valA", valA, 64'h1234);

    // cmov not taken, then taken
    set_wb(1'b1, 4'h2, 4'h0, 4'h3, 1'b0, 64'hAA, 64'h0);
    step();
    set_dec(1'b1, 4'h6, 4'h3, 4'h5);
    step();
    check_eq("cmov_nt_r3", valA, 64'h0);
    check_eq("cmov_nt_r5", valB, 64'h1234);
    set_wb(1'b1, 4'h2, 4'h0, 4'h3, 1'b1, 64'hAA, 64'h0);
    step();
    set_dec(1'b1, 4'h6, 4'h3, 4'hF);
    step();
    check_eq("cmov_t_r3", valA, 64'hAA);

    // popq %rsp: M write wins
    set_wb(1'b1, 4'hB, 4'h4, 4'hF, 1'b0, 64'h100, 64'h200);
    step();
    set_dec(1'b1, 4'h9, 4'hF, 4'hF);
    step();
    check_eq("popq_rsp_valA", valA, 64'h200);
    check_eq("popq_rsp_valB", valB, 64'h200);

    // mrmovq -> r8 via M port; call updates RSP via E port
    set_wb(1'b1, 4'h5, 4'h8, 4'h1, 1'b0, 64'hBEEF, 64'hDEAD);
    step();
    set_wb(1'b1, 4'h8, 4'hF, 4'hF, 1'b0, 64'h300, 64'h0);
    step();
    set_dec(1'b1, 4'h2, 4'h8, 4'hF);
    step();
    check_eq("mrmov_r8", valA, 64'hDEAD);
    check_eq("rrmov_valB_none", valB, 64'h0);
    set_dec(1'b1, 4'hB, 4'h2, 4'h2);
    step();
    check_eq("call_rsp_valA", valA, 64'h300);
    check_eq("call_rsp_valB", valB, 64'h300);

    // halt reads nothing even with real register fields
    set_dec(1'b1, 4'h0, 4'h5, 4'h5);
    step();
    check_eq("halt_valA", valA, 64'h0);
    check_eq("halt_valB", valB, 64'h0);

    // Same-cycle write of r7 and read of r7
`ifdef DECODE_WB_FORWARD_EN
    exp_fwd = 64'h55;
`else
    exp_fwd = 64'h0;
`endif
    set_wb(1'b1, 4'h3, 4'hF, 4'h7, 1'b0, 64'h55, 64'h0);
    set_dec(1'b1, 4'h6, 4'h7, 4'h7);
    step();
    check_eq("same_cyc_valA", valA, exp_fwd);
    check_eq("same_cyc_valB", valB, exp_fwd);
    set_dec(1'b1, 4'h6, 4'h7, 4'hF);
    step();
    check_eq("after_wr_r7", valA, 64'h55);

    // Reset wins over a simultaneous write of r1 and a decode
    reset = 1'b1;
    set_wb(1'b1, 4'h3, 4'hF, 4'h1, 1'b0, 64'hFF, 64'h0);
    set_dec(1'b1, 4'h6, 4'h7, 4'h5);
    step();
    check_eq("rst_wr_out_valid", {63'h0, out_valid}, 64'h0);
    check_eq("rst_wr_valA", valA, 64'h0);
    reset = 1'b0;
    set_dec(1'b1, 4'h6, 4'h1, 4'h5);
    step();
    check_eq("rst_r1_cleared", valA, 64'h0);
    check_eq("rst_r5_cleared", valB, 64'h0);
    set_dec(1'b1, 4'h9, 4'hF, 4'hF);
    step();
    check_eq("rst_rsp_cleared", valA, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
